bi_run_controller: RTL and testbench
====================================

Name: bi_run_controller

Overview:
Sequencing FSM that drives the bus-invert datapath's enable strobes for one measurement run, and collects its result.
- A run is: seed prime, pipeline fill, NUM_WORDS measured words, one-cycle done pulse, then result hold.
- It samples the datapath's isequal each measured cycle and reports mismatch count and pass/fail.
- It sits directly upstream of the datapath and is the sole source of its en_* and done inputs.

Parameters:
NUM_WORDS, 2000, measured words per run (>=1)
PIPE_LAT, 4, encode->bus->decode->compare pipeline latency in cycles (>=1)
CNT_W, 16, width of word_count and phase counter; must hold max(NUM_WORDS, PIPE_LAT)
ERR_W, 16, width of err_count (saturating)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle run request; honoured only in IDLE or HOLD
abort  in  1  terminate current run
err_inject  in  1  request error-generator enable during RUN
isequal  in  1  datapath comparator result
en_gen_data, en_gen_err, en_enc, en_bus, en_dec, en_trans_count, en_bf1, en_bf2, en_k_comp  out  1 each  datapath enables
done  out  1  one-cycle end-of-run pulse; latches transition counters downstream
busy  out  1  high in PRIME, FILL, RUN, DONE
word_count  out  CNT_W  measured words completed
err_count  out  ERR_W  mismatches observed in RUN
pass  out  1  valid in HOLD: 1 if err_count==0

Behaviour:
- Reset (async): state=IDLE; every output 0; internal phase counter 0.
- All enables and done/busy are Moore outputs decoded from the state register. They change on the same edge as the state, with no input-to-output combinational path.
- States and transitions (one transition per rising edge):
  - IDLE: all enables 0. start & !abort -> PRIME; clear word_count, err_count, pass.
  - PRIME (1 cycle): en_gen_data=1 only; this gives the generator its load rising edge. -> FILL; phase=0.
  - FILL (PIPE_LAT cycles): en_gen_data, en_enc, en_bus, en_dec, en_trans_count, en_bf1, en_bf2, en_k_comp =1. isequal ignored. phase increments; at phase==PIPE_LAT-1 -> RUN.
  - RUN (NUM_WORDS cycles): same enables as FILL.
    - en_gen_err = err_inject (combinational gate on the RUN decode; the only input-dependent output).
    - Each cycle: word_count+1; if isequal==0, err_count+1, saturating at 2^ERR_W-1.
    - When word_count==NUM_WORDS-1 at the edge -> DONE (word_count reaches NUM_WORDS).
  - DONE (1 cycle): done=1, all enables 0, busy=1. pass <= (err_count==0). -> HOLD.
  - HOLD: busy=0; word_count, err_count, pass held. start & !abort -> PRIME (restart, counters cleared). abort -> IDLE with pass cleared.
- abort in PRIME/FILL/RUN/DONE: next state IDLE.
  - word_count and err_count freeze at current values; pass=0.
  - done is not asserted if abort is sampled while in RUN.
  - abort sampled in DONE still lets the DONE pulse complete that cycle.
- Simultaneous start & abort: abort wins.
- start in PRIME/FILL/RUN/DONE: ignored, no queuing.
- Async reset mid-run: immediate IDLE, outputs 0; the run is lost.
- Latency: start sampled at edge t gives PRIME in cycle t+1, first RUN cycle at t+2+PIPE_LAT, done in cycle t+2+PIPE_LAT+NUM_WORDS.
- No arithmetic wrap: word_count never exceeds NUM_WORDS; err_count saturates.

Test Plan:
1. Assert rst mid-RUN with NUM_WORDS=8 -> same cycle all outputs 0; busy=0; after release, state IDLE; no done.
2. NUM_WORDS=8, PIPE_LAT=4, isequal=1, start at edge 0:
   - PRIME cycle 1 (only en_gen_data).
   - FILL cycles 2-5, RUN cycles 6-13.
   - done=1 in cycle 14 only; HOLD from 15 with word_count=8, err_count=0, pass=1.
3. As 2, with isequal=0 in FILL cycles 2-5 and in RUN cycles 7, 9, 10 -> err_count=3, pass=0; FILL mismatches not counted.
4. As 2, abort in cycle 9 -> IDLE from cycle 10; all enables 0; word_count=4 frozen; done never pulses; pass=0.
5. ERR_W=2, NUM_WORDS=8, isequal=0 throughout RUN -> err_count stops at 3; word_count=8; pass=0.
6. start pulsed during RUN -> ignored, run completes normally. err_inject=1 in RUN only -> en_gen_err high only in cycles 6-13. start in HOLD -> PRIME next cycle, counters cleared to 0.

Source files
------------

// File: rtl/bi_run_controller.sv
// Run sequencer for the bus-invert datapath. It steps through seed prime, pipeline fill,
// the measured words, a done pulse and a result hold, and tallies comparator mismatches.
//
// state | meaning
// IDLE  | no run active, all enables low
// PRIME | one cycle with only the generator enabled, so the generator sees its load edge
// FILL  | PIPE_LAT cycles with the full pipeline enabled; compare results are ignored
// RUN   | NUM_WORDS measured cycles; word and mismatch counting
// DONE  | one-cycle done pulse; pass is resolved here
// HOLD  | run results are held until the next start or an abort
module bi_run_controller #(
  parameter int NUM_WORDS = 2000,
  parameter int PIPE_LAT  = 4,
  parameter int CNT_W     = 16,
  parameter int ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             err_inject,
  input  logic             isequal,
  output logic             en_gen_data,
  output logic             en_gen_err,
  output logic             en_enc,
  output logic             en_bus,
  output logic             en_dec,
  output logic             en_trans_count,
  output logic             en_bf1,
  output logic             en_bf2,
  output logic             en_k_comp,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] word_count,
  output logic [ERR_W-1:0] err_count,
  output logic             pass
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_FILL  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(NUM_WORDS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             pass_q, pass_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      word_count_q <= '0;
      err_count_q  <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      word_count_q <= word_count_d;
      err_count_q  <= err_count_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    pass_d       = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d      = S_PRIME;
          word_count_d = '0;
          err_count_d  = '0;
          pass_d       = 1'b0;
        end
      end

      S_PRIME: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          state_d = S_FILL;
          phase_d = '0;
        end
      end

      S_FILL: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else if (phase_q == PHASE_LAST) begin
          state_d = S_RUN;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end

      S_RUN: begin
        // The word in flight on an abort edge still counts; only the done pulse is lost.
        word_count_d = word_count_q + CNT_W'(1);
        if (!isequal && (err_count_q != ERR_MAX)) begin
          err_count_d = err_count_q + ERR_W'(1);
        end
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else if (word_count_q == WORD_LAST) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          state_d = S_HOLD;
          pass_d  = (err_count_q == '0);
        end
      end

      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else if (start) begin
          state_d      = S_PRIME;
          word_count_d = '0;
          err_count_d  = '0;
          pass_d       = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        pass_d  = 1'b0;
      end
    endcase
  end

  logic pipe_en;

  // Everything but en_gen_err is a pure state decode.
  always_comb begin
    pipe_en        = (state_q == S_FILL) || (state_q == S_RUN);
    en_gen_data    = pipe_en || (state_q == S_PRIME);
    en_gen_err     = (state_q == S_RUN) && err_inject;
    en_enc         = pipe_en;
    en_bus         = pipe_en;
    en_dec         = pipe_en;
    en_trans_count = pipe_en;
    en_bf1         = pipe_en;
    en_bf2         = pipe_en;
    en_k_comp      = pipe_en;
    done           = (state_q == S_DONE);
    busy           = (state_q == S_PRIME) || (state_q == S_FILL) ||
                     (state_q == S_RUN)   || (state_q == S_DONE);
  end

  assign word_count = word_count_q;
  assign err_count  = err_count_q;
  assign pass       = pass_q;

endmodule

// File: tb/tb_bi_run_controller.sv
// Bench for bi_run_controller: directed scenarios plus a random run, all checked against
// a run-position model (cycle index within a run) instead of a state machine.
module tb_bi_run_controller;
  localparam int N      = 8;
  localparam int P      = 4;
  localparam int CNT_W  = 16;
  localparam int ERR_W  = 16;
  localparam int ERR_W2 = 2;
  localparam int DONE_POS = P + N + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, err_inject = 1'b0, isequal = 1'b1;

  logic en_gen_data, en_gen_err, en_enc, en_bus, en_dec, en_trans_count;
  logic en_bf1, en_bf2, en_k_comp, done, busy, pass;
  logic [CNT_W-1:0] word_count;
  logic [ERR_W-1:0] err_count;

  logic en_gen_data2, en_gen_err2, en_enc2, en_bus2, en_dec2, en_trans_count2;
  logic en_bf12, en_bf22, en_k_comp2, done2, busy2, pass2;
  logic [CNT_W-1:0]  word_count2;
  logic [ERR_W2-1:0] err_count2;

  int errors = 0;
  int checks = 0;

  int m_pos, m_words, m_err, m_err2;
  bit m_pass;

  always #5 clk = ~clk;

  bi_run_controller #(.NUM_WORDS(N), .PIPE_LAT(P), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .err_inject(err_inject),
    .isequal(isequal), .en_gen_data(en_gen_data), .en_gen_err(en_gen_err),
    .en_enc(en_enc), .en_bus(en_bus), .en_dec(en_dec), .en_trans_count(en_trans_count),
    .en_bf1(en_bf1), .en_bf2(en_bf2), .en_k_comp(en_k_comp), .done(done), .busy(busy),
    .word_count(word_count), .err_count(err_count), .pass(pass)
  );

  bi_run_controller #(.NUM_WORDS(N), .PIPE_LAT(P), .CNT_W(CNT_W), .ERR_W(ERR_W2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .err_inject(err_inject),
    .isequal(isequal), .en_gen_data(en_gen_data2), .en_gen_err(en_gen_err2),
    .en_enc(en_enc2), .en_bus(en_bus2), .en_dec(en_dec2), .en_trans_count(en_trans_count2),
    .en_bf1(en_bf12), .en_bf2(en_bf22), .en_k_comp(en_k_comp2), .done(done2), .busy(busy2),
    .word_count(word_count2), .err_count(err_count2), .pass(pass2)
  );

  function automatic logic [10:0] dut_vec();
    return {en_gen_data, en_gen_err, en_enc, en_bus, en_dec, en_trans_count,
            en_bf1, en_bf2, en_k_comp, done, busy};
  endfunction

  function automatic logic [10:0] dut_vec2();
    return {en_gen_data2, en_gen_err2, en_enc2, en_bus2, en_dec2, en_trans_count2,
            en_bf12, en_bf22, en_k_comp2, done2, busy2};
  endfunction

  // Run position: 0 = idle/hold, 1 = prime, 2..P+1 = fill, P+2..P+N+1 = measured, P+N+2 = done.
  function automatic bit in_run(input int p);
    return (p >= P + 2) && (p <= P + N + 1);
  endfunction

  function automatic logic [10:0] model_vec();
    logic ld, pipe, meas;
    ld   = (m_pos >= 1) && (m_pos <= P + N + 1);
    pipe = (m_pos >= 2) && (m_pos <= P + N + 1);
    meas = in_run(m_pos);
    return {ld, meas && err_inject, {7{pipe}}, m_pos == DONE_POS, m_pos > 0};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_words = 0; m_err = 0; m_err2 = 0; m_pass = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic a, input logic eq);
    if (in_run(m_pos)) begin
      m_words++;
      if (!eq) begin
        if (m_err < (1 << ERR_W) - 1) m_err++;
        if (m_err2 < (1 << ERR_W2) - 1) m_err2++;
      end
    end
    if (m_pos > 0 && a) begin
      m_pos = 0; m_pass = 1'b0;
    end else if (m_pos == 0) begin
      if (s && !a) begin
        m_pos = 1; m_words = 0; m_err = 0; m_err2 = 0; m_pass = 1'b0;
      end else if (a) begin
        m_pass = 1'b0;
      end
    end else if (m_pos == DONE_POS) begin
      m_pos = 0; m_pass = (m_err == 0);
    end else begin
      m_pos++;
    end
  endtask

  task automatic step(input logic s, input logic a, input logic eq, input logic inj);
    start = s; abort = a; isequal = eq; err_inject = inj;
    @(posedge clk);
    model_edge(s, a, eq);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (dut_vec() !== 11'd0 || word_count !== '0 || err_count !== '0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got vec=%b wc=%0d ec=%0d pass=%b required all 0",
               dut_vec(), word_count, err_count, pass);
    end
    #9 rst = 1'b0;
    model_reset();
    #4;
    for (int cur = 0; cur < 8; cur++) step(cur == 0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (en_enc !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prerun got en_enc=%b busy=%b required 1 1", en_enc, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 11'd0 || word_count !== '0 || err_count !== '0 || pass !== 1'b0 ||
        dut_vec2() !== 11'd0) begin
      errors++;
      $display("FAIL reset_midrun got vec=%b vec2=%b wc=%0d ec=%0d pass=%b required all 0",
               dut_vec(), dut_vec2(), word_count, err_count, pass);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    for (int cur = 0; cur < 20; cur++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (dut_vec() !== 11'd0 || word_count !== '0) begin
        errors++;
        $display("FAIL reset_after cycle=%0d got vec=%b wc=%0d required 0 0",
                 cur, dut_vec(), word_count);
      end
    end
  endtask

  task automatic test_clean_run();
    int done_cnt = 0;
    int done_cyc = -1;
    for (int cur = 0; cur < 16; cur++) begin
      step(cur == 0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL clean_outs cycle=%0d got=%b required=%b", cur + 1, dut_vec(), model_vec());
      end
      if (cur + 1 == 1) begin
        checks++;
        if (dut_vec() !== 11'b1_0_0000000_0_1) begin
          errors++;
          $display("FAIL clean_prime got=%b required=%b", dut_vec(), 11'b1_0_0000000_0_1);
        end
      end
      if (cur + 1 == 6) begin
        checks++;
        if (dut_vec() !== 11'b1_0_1111111_0_1) begin
          errors++;
          $display("FAIL clean_first_run got=%b required=%b", dut_vec(), 11'b1_0_1111111_0_1);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cur + 1;
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 14) begin
      errors++;
      $display("FAIL clean_done got count=%0d cycle=%0d required 1 14", done_cnt, done_cyc);
    end
    checks++;
    if (word_count !== CNT_W'(8) || err_count !== '0 || pass !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clean_hold got wc=%0d ec=%0d pass=%b busy=%b required 8 0 1 0",
               word_count, err_count, pass, busy);
    end
  endtask

  task automatic test_fill_errors();
    for (int cur = 0; cur < 16; cur++) begin
      step(cur == 0, 1'b0, !((cur >= 2 && cur <= 5) || cur == 7 || cur == 9 || cur == 10), 1'b0);
      checks++;
      if (dut_vec() !== model_vec() || err_count !== ERR_W'(m_err)) begin
        errors++;
        $display("FAIL fill_err_outs cycle=%0d got vec=%b ec=%0d required vec=%b ec=%0d",
                 cur + 1, dut_vec(), err_count, model_vec(), m_err);
      end
    end
    checks++;
    if (err_count !== ERR_W'(3) || pass !== 1'b0 || word_count !== CNT_W'(8)) begin
      errors++;
      $display("FAIL fill_err_hold got ec=%0d pass=%b wc=%0d required 3 0 8",
               err_count, pass, word_count);
    end
  endtask

  task automatic test_hold_restart();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (word_count !== '0 || err_count !== '0 || dut_vec() !== 11'b1_0_0000000_0_1) begin
      errors++;
      $display("FAIL restart_clear got wc=%0d ec=%0d vec=%b required 0 0 prime",
               word_count, err_count, dut_vec());
    end
    for (int cur = 1; cur < 16; cur++) step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pass !== 1'b1) begin
      errors++;
      $display("FAIL restart_pass got=%b required=1", pass);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (pass !== 1'b0 || busy !== 1'b0 || word_count !== CNT_W'(8)) begin
      errors++;
      $display("FAIL hold_abort got pass=%b busy=%b wc=%0d required 0 0 8", pass, busy, word_count);
    end
  endtask

  task automatic test_abort();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_same got busy=%b required=0", busy);
    end
    begin
      int done_cnt = 0;
      for (int cur = 0; cur < 18; cur++) begin
        step(cur == 0, cur == 9, 1'b1, 1'b0);
        if (done === 1'b1) done_cnt++;
        if (cur + 1 >= 10) begin
          checks++;
          if (dut_vec() !== 11'd0 || word_count !== CNT_W'(4) || pass !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle cycle=%0d got vec=%b wc=%0d pass=%b required 0 4 0",
                     cur + 1, dut_vec(), word_count, pass);
          end
        end
      end
      checks++;
      if (done_cnt !== 0) begin
        errors++;
        $display("FAIL abort_done got count=%0d required=0", done_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    for (int cur = 0; cur < 16; cur++) step(cur == 0, 1'b0, !(cur >= 6 && cur <= 13), 1'b0);
    checks++;
    if (err_count2 !== 2'd3 || word_count2 !== CNT_W'(8) || pass2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_hold got ec=%0d wc=%0d pass=%b required 3 8 0",
               err_count2, word_count2, pass2);
    end
    checks++;
    if (err_count !== ERR_W'(8)) begin
      errors++;
      $display("FAIL sat_wide got ec=%0d required=8", err_count);
    end
  endtask

  task automatic test_start_ignored_inject();
    int inj_cnt = 0;
    int inj_first = -1;
    int inj_last = -1;
    int done_cyc = -1;
    for (int cur = 0; cur < 16; cur++) begin
      step(cur == 0 || cur == 8 || cur == 13, 1'b0, 1'b1, 1'b1);
      if (en_gen_err === 1'b1) begin
        inj_cnt++;
        if (inj_first < 0) inj_first = cur + 1;
        inj_last = cur + 1;
      end
      if (done === 1'b1) done_cyc = cur + 1;
    end
    checks++;
    if (inj_cnt !== 8 || inj_first !== 6 || inj_last !== 13) begin
      errors++;
      $display("FAIL inject_window got count=%0d first=%0d last=%0d required 8 6 13",
               inj_cnt, inj_first, inj_last);
    end
    checks++;
    if (done_cyc !== 14 || word_count !== CNT_W'(8) || pass !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored got done_cycle=%0d wc=%0d pass=%b required 14 8 1",
               done_cyc, word_count, pass);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1);
      checks++;
      if (dut_vec() !== model_vec() || word_count !== CNT_W'(m_words) ||
          err_count !== ERR_W'(m_err) || pass !== m_pass) begin
        errors++;
        $display("FAIL rand_main i=%0d got vec=%b wc=%0d ec=%0d pass=%b required vec=%b wc=%0d ec=%0d pass=%b",
                 i, dut_vec(), word_count, err_count, pass, model_vec(), m_words, m_err, m_pass);
      end
      checks++;
      if (err_count2 !== ERR_W2'(m_err2) || pass2 !== m_pass) begin
        errors++;
        $display("FAIL rand_sat i=%0d got ec=%0d pass=%b required ec=%0d pass=%b",
                 i, err_count2, pass2, m_err2, m_pass);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_run();
    test_fill_errors();
    test_hold_restart();
    test_abort();
    test_saturation();
    test_start_ignored_inject();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
